fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 35 +++
 rtl/fifo_sync_param.sv | 127 ++++++++++++
 tb/tb_fifo_sync_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: occupancy FSM state encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, registered read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its word between reads; a same-edge write to the
  // read address returns the old word, which is what a full-FIFO swap needs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO: occupancy FSM, pointers, count, status and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  fifo_state_e   state_q, state_nxt;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_acc, rd_acc;
  logic          ovf_q, udf_q;
  logic          rd_vld_p1;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc = rd_en & ~flush & (state_q != S_EMPTY);
  assign wr_acc = wr_en & ~flush & ((state_q != S_FULL) | rd_acc);

  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (wr_acc) state_nxt = S_PART;
        S_PART: begin
          if (wr_acc && !rd_acc && count_q == DEPTH_M1) begin
            state_nxt = S_FULL;
          end else if (rd_acc && !wr_acc && count_q == ONE) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL:  if (rd_acc && !wr_acc) state_nxt = S_PART;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
      ovf_q     <= ovf_q | (wr_en & ~wr_acc);
      udf_q     <= udf_q | (rd_en & ~rd_acc);
      rd_vld_p1 <= rd_acc;
    end
  end

  // Stage p1: registered read word and its valid
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign rd_valid     = rd_vld_p1;
  assign full         = (state_q == S_FULL);
  assign empty        = (state_q == S_EMPTY);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param (DATA_W=8, DEPTH=4): vector table, corner sequences, random vs queue model.
module tb_fifo_sync_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF     = 2;
  localparam int AE     = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic             rd_valid, full, empty, almost_full, almost_empty;
  logic [2:0]       count;
  logic             overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  // reference model: plain queue of stored words plus sticky flags
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_vld;
  logic [7:0] m_dout;

  fifo_sync_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         f, w, r;
    logic [7:0] d;
    int         c;
    bit         v;
    logic [7:0] q;
    bit         fu, em, ov, un;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_vld  = 1'b0;
    m_dout = 8'h00;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},        32'(count),        32'(n));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_vld));
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ".full"},         32'(full),         32'(n == DEPTH));
    chk({tag, ".empty"},        32'(empty),        32'(n == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_udf));
  endtask

  // drive one cycle, advance model by the same rules, check after the edge
  task automatic step(input string tag, input bit f, input bit w, input bit r, input logic [7:0] d);
    bit rok, wok;
    flush = f; wr_en = w; rd_en = r; data_in = d;
    rok = r && !f && (mq.size() > 0);
    wok = w && !f && ((mq.size() < DEPTH) || rok);
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_vld = 1'b0;
    end else begin
      m_vld = rok;
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #3 reset_n = 1'b0;
    model_clear();
    #1 check_model(tag);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // f w r  d      c  v  q      fu em ov un
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h44, 4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h55, 4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h66, 1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h77, 1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1};

    // power-on reset
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_model("reset");
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1 check_model("post_reset");

    // fixed vectors
    for (int i = 0; i < 15; i++) begin
      flush = tbl[i].f; wr_en = tbl[i].w; rd_en = tbl[i].r; data_in = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.count", i),        32'(count),        32'(tbl[i].c));
      chk($sformatf("tbl%0d.rd_valid", i),     32'(rd_valid),     32'(tbl[i].v));
      chk($sformatf("tbl%0d.data_out", i),     32'(data_out),     32'(tbl[i].q));
      chk($sformatf("tbl%0d.full", i),         32'(full),         32'(tbl[i].fu));
      chk($sformatf("tbl%0d.empty", i),        32'(empty),        32'(tbl[i].em));
      chk($sformatf("tbl%0d.almost_full", i),  32'(almost_full),  32'(tbl[i].c >= AF));
      chk($sformatf("tbl%0d.almost_empty", i), 32'(almost_empty), 32'(tbl[i].c <= AE));
      chk($sformatf("tbl%0d.overflow", i),     32'(overflow),     32'(tbl[i].ov));
      chk($sformatf("tbl%0d.underflow", i),    32'(underflow),    32'(tbl[i].un));
    end
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    do_reset("rst_a");

    // steady-state swap at count 2, pointers wrap several times
    step("swap_fill", 1'b0, 1'b1, 1'b0, 8'hA0);
    step("swap_fill", 1'b0, 1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 10; i++) begin
      step("swap", 1'b0, 1'b1, 1'b1, 8'(8'hB0 + i));
    end
    chk("swap.count_const", 32'(count), 32'd2);
    step("swap_drain", 1'b0, 1'b0, 1'b1, 8'h00);
    step("swap_drain", 1'b0, 1'b0, 1'b1, 8'h00);

    // fill to full with one rejected write, then flush
    for (int i = 0; i < 5; i++) begin
      step("flush_fill", 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    end
    step("flush_full_swap", 1'b0, 1'b1, 1'b1, 8'hCF);
    step("flush", 1'b1, 1'b1, 1'b1, 8'hEE);
    chk("flush.overflow_clear", 32'(overflow), 32'd0);
    step("flush_wr", 1'b0, 1'b1, 1'b0, 8'hC5);
    step("flush_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("flush.new_data", 32'(data_out), 32'hC5);

    // reset asserted between edges while a write burst is in progress
    step("burst", 1'b0, 1'b1, 1'b0, 8'hD1);
    step("burst", 1'b0, 1'b1, 1'b1, 8'hD2);
    wr_en = 1'b1; data_in = 8'hD3;
    #3 reset_n = 1'b0;
    model_clear();
    #1 check_model("midburst_rst");
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_rd.underflow", 32'(underflow), 32'd1);

    do_reset("rst_b");

    // random traffic, write bias alternates so the FIFO both fills and drains
    for (int i = 0; i < 400; i++) begin
      bit f, w, r;
      int wp;
      wp = ((i / 40) % 2 == 0) ? 75 : 30;
      f = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < 50);
      step("rand", f, w, r, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
